serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_pkg.sv | 20 ++
 rtl/serial_add_ctrl_if.sv | 36 +++
 rtl/serial_add_ctrl_fa.sv | 19 +
 rtl/serial_add_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// ============================================================================
// Module : serial_add_pkg
// Brief  : Shared state encoding and default width for the bit-serial adder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam int SA_DEFAULT_WIDTH = 8;

endpackage

`default_nettype wire

// File: rtl/serial_add_ctrl_if.sv
// ============================================================================
// Module : serial_add_ctrl_if
// Brief  : Operand/result valid-ready bundle for serial_add_ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

`default_nettype wire

// File: rtl/serial_add_ctrl_fa.sv
// ============================================================================
// Module : fa
// Brief  : Single-bit full adder shared by the serial adder datapath.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fa (
  input  wire logic a_i,
  input  wire logic b_i,
  input  wire logic c_i,
  output logic      s_o,
  output logic      co_o
);
  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module : serial_add_ctrl
// Brief  : Bit-serial adder, LSB first, one full adder time-shared over WIDTH clocks.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  wire logic          clk,
  input  wire logic          rst,
  serial_add_ctrl_if.slave   bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s;
  logic             fa_cy;
  logic [WIDTH-1:0] sum_sh_next;
  logic             unused_sum_sh_lsb;

  fa u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .c_i  (carry_q),
    .s_o  (fa_s),
    .co_o (fa_cy)
  );

  // The oldest partial-sum bit is shifted out on the final cycle, so bit 0 is never read.
  assign unused_sum_sh_lsb = sum_sh_q[0];

  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_sh_next = fa_s;
    end else begin : g_wn
      assign sum_sh_next = {fa_s, sum_sh_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          carry_d  = bus.cin;
          cnt_d    = '0;
          sum_sh_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        sum_sh_d = sum_sh_next;
        carry_d  = fa_cy;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // carry_q here is the carry into the MSB, so xor with its carry out gives signed overflow.
        if (cnt_q == CW'(WIDTH - 1)) begin
          ovf_d   = carry_q ^ fa_cy;
          cout_d  = fa_cy;
          sum_d   = sum_sh_next;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// Module : tb_serial_add_ctrl
// Brief  : Scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic rnd_en = 1'b0;
  logic pv8 = 1'b0;
  logic pv1 = 1'b0;

  exp_t q8[$];
  exp_t q1[$];
  int   acc_log8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  serial_add_ctrl_if #(.WIDTH(W)) bus8 ();
  serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_add_ctrl #(.WIDTH(W)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Plain integer addition; overflow when both operands share a sign the sum lacks.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input int acc);
    exp_t        e;
    logic [32:0] total;
    logic [32:0] mask;
    total  = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    mask   = (33'd1 << w) - 33'd1;
    e.sum  = 32'(total & mask);
    e.cout = total[w];
    e.ovf  = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
    e.acc  = acc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus8.in_valid && bus8.in_ready) begin
      q8.push_back(model(W, 32'(bus8.a), 32'(bus8.b), bus8.cin, cyc + 1));
      acc_log8.push_back(cyc + 1);
    end
    if (!rst && bus1.in_valid && bus1.in_ready)
      q1.push_back(model(1, 32'(bus1.a), 32'(bus1.b), bus1.cin, cyc + 1));
  end

  always @(negedge clk) begin
    if (rst) begin
      pv8 = 1'b0;
      pv1 = 1'b0;
    end else begin
      if (bus8.out_valid && (q8.size() == 0)) begin
        chk("w8_unexpected_out", 1, 0);
      end else if (bus8.out_valid) begin
        if (!pv8) chk("w8_latency", 64'(cyc - q8[0].acc), W);
        if (bus8.out_ready) begin
          chk("w8_sum", bus8.sum, q8[0].sum[W-1:0]);
          chk("w8_cout", bus8.cout, q8[0].cout);
          chk("w8_ovf", bus8.ovf, q8[0].ovf);
          void'(q8.pop_front());
        end
      end
      if (bus1.out_valid && (q1.size() == 0)) begin
        chk("w1_unexpected_out", 1, 0);
      end else if (bus1.out_valid) begin
        if (!pv1) chk("w1_latency", 64'(cyc - q1[0].acc), 1);
        if (bus1.out_ready) begin
          chk("w1_sum", bus1.sum, q1[0].sum[0]);
          chk("w1_cout", bus1.cout, q1[0].cout);
          chk("w1_ovf", bus1.ovf, q1[0].ovf);
          void'(q1.pop_front());
        end
      end
      pv8 = bus8.out_valid;
      pv1 = bus1.out_valid;
    end
  end

  always @(posedge clk) if (rnd_en) begin
    #1 bus8.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send8(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input bit keep);
    int n = 0;
    @(posedge clk); #1;
    bus8.in_valid = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = c;
    do begin @(negedge clk); n++; end while (!bus8.in_ready && n < 200);
    if (!bus8.in_ready) chk("w8_accept_timeout", bus8.in_ready, 1);
    @(posedge clk); #1;
    if (!keep) bus8.in_valid = 1'b0;
  endtask

  task automatic send1(input logic a, input logic b, input logic c);
    int n = 0;
    @(posedge clk); #1;
    bus1.in_valid = 1'b1; bus1.a = a; bus1.b = b; bus1.cin = c;
    do begin @(negedge clk); n++; end while (!bus1.in_ready && n < 50);
    if (!bus1.in_ready) chk("w1_accept_timeout", bus1.in_ready, 1);
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q8.size() != 0 || q1.size() != 0) && n < budget) begin @(negedge clk); n++; end
    chk("drain_w8", 64'(q8.size()), 0);
    chk("drain_w1", 64'(q1.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int seen;
    bus8.in_valid = 0; bus8.a = '0; bus8.b = '0; bus8.cin = 0; bus8.out_ready = 1;
    bus1.in_valid = 0; bus1.a = '0; bus1.b = '0; bus1.cin = 0; bus1.out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sum", bus8.sum, 0);
    chk("rst_cout", bus8.cout, 0);
    chk("rst_ovf", bus8.ovf, 0);
    chk("rst_out_valid", bus8.out_valid, 0);
    chk("rst_busy", bus8.busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", bus8.in_ready, 1);

    send8(8'h5A, 8'h3C, 1'b0, 0);
    drain(40);
    chk("t1_sum_held", bus8.sum, 8'h96);
    chk("t1_ovf_held", bus8.ovf, 1);

    send8(8'hFF, 8'h01, 1'b0, 0);
    send8(8'h7F, 8'h00, 1'b1, 0);
    drain(60);
    chk("t2_sum_held", bus8.sum, 8'h80);

    bus8.out_ready = 1'b0;
    send8(8'h12, 8'h34, 1'b0, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus8.out_valid && n < 40);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", bus8.out_valid, 1);
      chk("bp_sum", bus8.sum, 8'h46);
      chk("bp_in_ready", bus8.in_ready, 0);
      @(posedge clk); #1;
      if (i == 1) begin bus8.in_valid = 1; bus8.a = 8'hAA; bus8.b = 8'h01; end
      if (i == 2) bus8.in_valid = 0;
      @(negedge clk);
    end
    @(posedge clk); #1 bus8.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_back_idle", bus8.in_ready, 1);
    chk("bp_out_valid_low", bus8.out_valid, 0);
    drain(10);

    send8(8'h33, 8'h44, 1'b1, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_sum", bus8.sum, 0);
    chk("abort_out_valid", bus8.out_valid, 0);
    chk("abort_busy", bus8.busy, 0);
    q8.delete();
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (bus8.out_valid) seen++;
    end
    chk("abort_no_out_valid", 64'(seen), 0);
    send8(8'h01, 8'h01, 1'b0, 0);
    drain(40);
    chk("abort_next_sum", bus8.sum, 8'h02);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      send1(v[2], v[1], v[0]);
    end
    drain(20);

    base = acc_log8.size();
    for (int k = 0; k < 3; k++)
      send8(8'($urandom), 8'($urandom), 1'($urandom), 1);
    bus8.in_valid = 0;
    drain(60);
    for (int k = 1; k < 3; k++)
      chk("b2b_spacing", 64'(acc_log8[base + k] - acc_log8[base + k - 1]), W + 2);

    rnd_en = 1'b1;
    for (int k = 0; k < 20; k++)
      send8(8'($urandom), 8'($urandom), 1'($urandom), 0);
    rnd_en = 1'b0;
    @(posedge clk); #2 bus8.out_ready = 1'b1;
    drain(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
